mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Load/store access controller between a core and a synchronous word RAM.
// One access is handled at a time. Each access is either a legal transfer
// that spends 1+WAIT_STATES cycles in ACCESS, or a misaligned/illegal one
// that skips straight to a one-cycle error response.
//
// state  | meaning
// IDLE   | no access pending, waiting for req
// ACCESS | RAM strobes active, wait-state down-counter running
// RESP   | done pulse, load data presented, may accept the next req
module mem_access_ctrl #(
  parameter int WAIT_STATES = 1,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              misalign,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  output logic [3:0]        ram_be,
  output logic              ram_we,
  output logic              ram_re,
  input  logic [31:0]       ram_q
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state;
  logic [2:0]  wait_cnt;
  logic [1:0]  size_q;
  logic [1:0]  lo_q;
  logic        uns_q;
  logic        resp_load;
  logic [31:0] rdata_hold;

  logic        req_err;
  logic [3:0]  be_next;
  logic [31:0] wd_next;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] rdata_fmt;

  // Address bits above the RAM window are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[31:ADDR_W+2];

  // Classify the incoming request and build its lane enables and replicated data.
  always_comb begin
    req_err = 1'b0;
    be_next = 4'b1111;
    wd_next = wdata;
    case (size)
      2'b00: begin
        be_next = 4'b0001 << addr[1:0];
        wd_next = {4{wdata[7:0]}};
      end
      2'b01: begin
        req_err = addr[0];
        be_next = addr[1] ? 4'b1100 : 4'b0011;
        wd_next = {2{wdata[15:0]}};
      end
      2'b10: begin
        req_err = (addr[1:0] != 2'b00);
      end
      default: begin
        req_err = 1'b1;
      end
    endcase
  end

  // Pick the addressed byte/half out of the RAM word and extend it.
  always_comb begin
    byte_sel  = ram_q[7:0];
    half_sel  = lo_q[1] ? ram_q[31:16] : ram_q[15:0];
    rdata_fmt = ram_q;
    case (lo_q)
      2'b00:   byte_sel = ram_q[7:0];
      2'b01:   byte_sel = ram_q[15:8];
      2'b10:   byte_sel = ram_q[23:16];
      default: byte_sel = ram_q[31:24];
    endcase
    case (size_q)
      2'b00:   rdata_fmt = uns_q ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   rdata_fmt = uns_q ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: rdata_fmt = ram_q;
    endcase
  end

  // RAM data only arrives during RESP, so load data is shown live there and held afterwards.
  always_comb begin
    rdata = rdata_hold;
    if (state == RESP) begin
      rdata = resp_load ? rdata_fmt : 32'b0;
    end
  end

  // Access sequencing FSM with registered strobes and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= 3'd0;
      size_q     <= 2'b00;
      lo_q       <= 2'b00;
      uns_q      <= 1'b0;
      resp_load  <= 1'b0;
      rdata_hold <= 32'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      misalign   <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= 32'b0;
      ram_be     <= 4'b0000;
      ram_we     <= 1'b0;
      ram_re     <= 1'b0;
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      case (state)
        ACCESS: begin
          if (wait_cnt == 3'd0) begin
            state  <= RESP;
            done   <= 1'b1;
            ram_we <= 1'b0;
            ram_re <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        default: begin
          if (state == RESP) begin
            rdata_hold <= rdata;
          end
          if (req) begin
            size_q <= size;
            lo_q   <= addr[1:0];
            uns_q  <= uns;
            busy   <= 1'b1;
            if (req_err) begin
              state     <= RESP;
              done      <= 1'b1;
              misalign  <= 1'b1;
              resp_load <= 1'b0;
              ram_be    <= 4'b0000;
            end else begin
              state     <= ACCESS;
              wait_cnt  <= 3'(WAIT_STATES);
              resp_load <= ~we;
              ram_addr  <= addr[ADDR_W+1:2];
              ram_be    <= be_next;
              ram_wdata <= wd_next;
              ram_we    <= we;
              ram_re    <= ~we;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a WAIT_STATES=1 instance for the
// main load/store/error/reset cases and a WAIT_STATES=0 instance for
// back-to-back requests.
module tb_mem_access_ctrl;

  localparam int WS = 1;

  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          cyc;
    logic        chk_ram;
    int          strobes;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [9:0]  ra;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        busy, done, misalign, ram_we, ram_re;
  logic [31:0] rdata, ram_wdata;
  logic [31:0] ram_q = 32'h0;
  logic [9:0]  ram_addr;
  logic [3:0]  ram_be;

  logic        req0 = 1'b0;
  logic        we0 = 1'b0, uns0 = 1'b0;
  logic [1:0]  size0 = 2'b10;
  logic [31:0] addr0 = 32'h0, wdata0 = 32'h0;
  logic        busy0, done0, misalign0, ram_we0, ram_re0;
  logic [31:0] rdata0, ram_wdata0;
  logic [31:0] ram_q0 = 32'h0;
  logic [9:0]  ram_addr0;
  logic [3:0]  ram_be0;

  logic [31:0] mem [256];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  exp_t        sb0[$];
  int          strobes = 0;
  logic [3:0]  s_be;
  logic [31:0] s_wd;
  logic [9:0]  s_ra;

  mem_access_ctrl #(.WAIT_STATES(WS), .ADDR_W(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misalign(misalign), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_be(ram_be), .ram_we(ram_we), .ram_re(ram_re), .ram_q(ram_q)
  );

  mem_access_ctrl #(.WAIT_STATES(0), .ADDR_W(10)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .size(size0), .uns(uns0),
    .addr(addr0), .wdata(wdata0), .busy(busy0), .done(done0), .rdata(rdata0),
    .misalign(misalign0), .ram_addr(ram_addr0), .ram_wdata(ram_wdata0),
    .ram_be(ram_be0), .ram_we(ram_we0), .ram_re(ram_re0), .ram_q(ram_q0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte-enabled synchronous RAM behind the main instance.
  always @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    if (ram_re) ram_q <= mem[ram_addr[7:0]];
  end

  // The second instance reads back its own word address as data.
  always @(posedge clk) begin
    if (ram_re0) ram_q0 <= {22'b0, ram_addr0};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Main monitor: tracks RAM strobes and scores each done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      strobes = 0;
    end else begin
      if (ram_we || ram_re) begin
        strobes++;
        s_be = ram_be;
        s_wd = ram_wdata;
        s_ra = ram_addr;
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("rdata", rdata, e.rdata);
          chk("misalign", {31'b0, misalign}, {31'b0, e.mis});
          chk("done_cycle", cyc, e.cyc);
          chk("strobe_cycles", strobes, e.strobes);
          if (e.chk_ram) begin
            chk("ram_be", {28'b0, s_be}, {28'b0, e.be});
            chk("ram_wdata", s_wd, e.wd);
            chk("ram_addr", {22'b0, s_ra}, {22'b0, e.ra});
          end
        end
        strobes = 0;
      end
    end
  end

  // Monitor for the zero-wait-state instance.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done0) begin
      if (sb0.size() == 0) begin
        chk("unexpected_done0", 32'd1, 32'd0);
      end else begin
        e = sb0.pop_front();
        chk("b2b_rdata", rdata0, e.rdata);
        chk("b2b_misalign", {31'b0, misalign0}, 32'd0);
        chk("b2b_done_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue one request (called #1 after a rising edge) and wait for its response.
  task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd_in,
                       input logic exp_mis, input logic [31:0] exp_rd,
                       input logic [3:0] exp_be, input logic [31:0] exp_wd);
    exp_t e;
    e.rdata   = exp_rd;
    e.mis     = exp_mis;
    e.cyc     = cyc + (exp_mis ? 1 : 2 + WS);
    e.chk_ram = !exp_mis;
    e.strobes = exp_mis ? 0 : 1 + WS;
    e.be      = exp_be;
    e.wd      = exp_wd;
    e.ra      = a[11:2];
    sb.push_back(e);
    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd_in;
    @(posedge clk); #1;
    req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    #1;
    if (sb.size() != 0) begin
      chk("response_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_misalign", {31'b0, misalign}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_strobes", {30'b0, ram_we, ram_re}, 32'd0);
    chk("rst_be", {28'b0, ram_be}, 32'd0);
    rst_n = 1'b1;

    issue(1, 2'b10, 0, 32'h20, 32'h000080F0, 0, 32'h0, 4'b1111, 32'h000080F0);
    issue(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 4'b1111, 32'hDEADBEEF);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, 4'b1111, 32'h0);
    chk("rdata_hold_idle", rdata, 32'hDEADBEEF);
    issue(0, 2'b00, 0, 32'h21, 32'h0, 0, 32'hFFFFFF80, 4'b0010, 32'h0);
    issue(0, 2'b00, 1, 32'h21, 32'h0, 0, 32'h00000080, 4'b0010, 32'h0);
    issue(0, 2'b01, 0, 32'h22, 32'h0, 0, 32'h00000000, 4'b1100, 32'h0);
    issue(0, 2'b01, 0, 32'h20, 32'h0, 0, 32'hFFFF80F0, 4'b0011, 32'h0);
    issue(0, 2'b01, 1, 32'h20, 32'h0, 0, 32'h000080F0, 4'b0011, 32'h0);
    issue(0, 2'b00, 0, 32'h20, 32'h0, 0, 32'hFFFFFFF0, 4'b0001, 32'h0);
    issue(1, 2'b00, 0, 32'h33, 32'h000000AB, 0, 32'h0, 4'b1000, 32'hABABABAB);
    issue(0, 2'b00, 1, 32'h33, 32'h0, 0, 32'h000000AB, 4'b1000, 32'h0);
    issue(0, 2'b00, 0, 32'h33, 32'h0, 0, 32'hFFFFFFAB, 4'b1000, 32'h0);
    issue(1, 2'b01, 0, 32'h12, 32'h00001234, 0, 32'h0, 4'b1100, 32'h12341234);
    issue(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h1234BEEF, 4'b1111, 32'h0);

    issue(0, 2'b10, 0, 32'h06, 32'h0, 1, 32'h0, 4'b0000, 32'h0);
    issue(1, 2'b01, 0, 32'h05, 32'h0000FFFF, 1, 32'h0, 4'b0000, 32'h0);
    issue(0, 2'b11, 0, 32'h08, 32'h0, 1, 32'h0, 4'b0000, 32'h0);
    issue(1, 2'b10, 0, 32'h13, 32'h11111111, 1, 32'h0, 4'b0000, 32'h0);

    // Reset in the middle of a store: no response may follow.
    req = 1'b1; we = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h40; wdata = 32'h55555555;
    @(posedge clk); #1;
    req = 1'b0;
    chk("store_in_access_we", {31'b0, ram_we}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_kills_ram_we", {31'b0, ram_we}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_be", {28'b0, ram_be}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h1234BEEF, 4'b1111, 32'h0);

    // Two loads with req held high on the zero-wait-state instance.
    begin
      exp_t e;
      int start;
      logic busy_ok;
      start = cyc;
      busy_ok = 1'b1;
      e.mis = 1'b0; e.chk_ram = 1'b0; e.strobes = 0; e.be = 4'b0; e.wd = 32'h0; e.ra = 10'h0;
      e.rdata = 32'h10; e.cyc = start + 2; sb0.push_back(e);
      e.rdata = 32'h11; e.cyc = start + 4; sb0.push_back(e);
      req0 = 1'b1; addr0 = 32'h40;
      for (int k = 1; k <= 5; k++) begin
        @(posedge clk); #1;
        if (k == 1) addr0 = 32'h44;
        if (k == 3) req0 = 1'b0;
        if (k <= 4 && !busy0) busy_ok = 1'b0;
      end
      chk("b2b_busy_held", {31'b0, busy_ok}, 32'd1);
      chk("b2b_busy_idle", {31'b0, busy0}, 32'd0);
      chk("b2b_all_done", sb0.size(), 32'd0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
